div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: clk input 1, the one clock, all state updates on the rising edge.
REQ-002 SHALL have rst input 1 as that reset: asynchronous, active-low, clears all state immediately.
REQ-003 SHALL have signed_div_i input 1: 1 = signed divide (DIV), 0 = unsigned (DIVU).
REQ-004 SHALL have opdata1_i input 32: dividend.
REQ-005 SHALL have opdata2_i input 32: divisor.
REQ-006 SHALL have start_i input 1: request a divide; level-held by EX until ready_o is seen.
REQ-007 SHALL have annul_i input 1: cancel the in-flight divide (pipeline flush).
REQ-008 SHALL have result_o output 64: {remainder[63:32], quotient[31:0]}, mapped to hi/lo by the writer.
REQ-009 SHALL have ready_o output 1: result_o valid.

Function
REQ-010 SHALL implement four states: FREE, BYZERO, ON, END.
REQ-011 In FREE, with start_i=1 and annul_i=0, SHALL latch operands at the edge and go to BYZERO if opdata2_i==0, else to ON with iteration count 0.
REQ-012 In FREE, start_i=1 with annul_i=1 SHALL be ignored; the state stays FREE.
REQ-013 Signed mode SHALL latch two's-complement magnitudes of the operands and record both signs; unsigned mode SHALL latch the raw operands.
REQ-014 ON SHALL perform one radix-2 restoring step per cycle, shifting {remainder,dividend} left 1, subtracting the divisor from the upper 33 bits, and keeping the difference and setting the quotient bit to 1 when it is non-negative.
REQ-015 The 33-bit subtraction SHALL be held in a 65-bit working register so bit 32 carries the borrow.
REQ-016 ON SHALL run exactly 32 steps; the edge completing step 32 SHALL move to END.
REQ-017 BYZERO SHALL move to END on the next edge with quotient=0 and remainder=0.
REQ-018 On entry to END in signed mode, the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 (wrap) and remainder 0; no exception is raised.
REQ-020 ready_o SHALL be 1 only in END; result_o SHALL equal the final value in END and 0 in every other state.
REQ-021 Latency SHALL be 33 edges from the accepting edge to ready_o=1 for a nonzero divisor, and 2 edges for a zero divisor.
REQ-022 END SHALL hold its output while start_i=1, and SHALL go to FREE on the first edge with start_i=0 (ready_o drops that edge).
REQ-023 annul_i=1 in BYZERO or ON SHALL force FREE on the next edge; no ready_o pulse is produced and partial state is discarded.
REQ-024 annul_i in END SHALL be ignored; exit from END is governed by start_i only.
REQ-025 A new divide SHALL not be accepted until FREE is re-entered, so a back-to-back divide needs at least one start_i=0 cycle.
REQ-026 Operand changes after the accepting edge SHALL have no effect on the result.

Reset
REQ-027 While rst=0, state SHALL be FREE, the iteration count 0, the working register 0, result_o=64'h0 and ready_o=0.
REQ-028 Reset asserted mid-divide SHALL abort it asynchronously, with no ready_o after release.
REQ-029 After release, the first edge SHALL behave as FREE.

Structure
REQ-030 The state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady, DivStart/Stop and DivResultWidth SHALL live in the shared defines.v header.
REQ-031 One combinational sub-module, div_step, SHALL hold the shift/subtract/select logic for one iteration (65-bit in, 65-bit out).
REQ-032 The FSM, counter and sign fix-up SHALL stay in div_unit.

Verification
REQ-033 SHALL cover: unsigned 100/7, start held -> ready_o=1 exactly 33 edges after acceptance, result_o={32'd2, 32'd14}.
REQ-034 SHALL cover: signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; and 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-035 SHALL cover: divisor 0, dividend 0x12345678 -> ready_o after 2 edges, result_o=0.
REQ-036 SHALL cover: annul_i pulse at step 10 -> FREE next edge, ready_o never rises; a following 0xFFFFFFFF/1 unsigned -> quotient 0xFFFFFFFF, remainder 0.
REQ-037 SHALL cover: rst low during ON step 20 -> outputs 0 immediately, FREE after release; then signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
REQ-038 SHALL cover: start_i held 5 cycles in END -> result stable; drop start_i -> ready_o=0 next edge; re-raise -> new divide accepted.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative 32-bit divider: FSM encodings, handshake
// levels, result width and the signed fix-up applied on completion.
package div_unit_pkg;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int unsigned DivResultWidth = 64;
  localparam logic [4:0]  DivLastStep    = 5'd31;

  // Quotient negated when operand signs differ; remainder follows the dividend.
  function automatic logic [63:0] div_sign_fix(input logic [31:0] quot,
                                               input logic [31:0] rem,
                                               input logic        neg_a,
                                               input logic        neg_b);
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    q_fix = (neg_a ^ neg_b) ? (~quot + 32'd1) : quot;
    r_fix = neg_a ? (~rem + 32'd1) : rem;
    return {r_fix, q_fix};
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {remainder,dividend} left, trial
// subtract the divisor from the upper 33 bits, keep the difference if non-negative.
module div_step (
  input  logic [64:0] work_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] work_o
);

  logic [64:0] shifted;
  logic [32:0] diff;
  logic        unused_msb;

  // Remainder stays below the divisor, so bit 64 is always zero on entry.
  assign unused_msb = work_i[64];
  assign shifted    = {work_i[63:0], 1'b0};
  assign diff       = shifted[64:32] - {1'b0, divisor_i};

  always_comb begin
    work_o = shifted;
    if (!diff[32]) begin
      work_o = {diff, shifted[31:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider with annul and start/ready
// handshake; result_o = {remainder, quotient} while ready_o is high.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  logic [1:0]                state_q, state_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [64:0]               work_q, work_d;
  logic [31:0]               divisor_q, divisor_d;
  logic                      neg_a_q, neg_a_d;
  logic                      neg_b_q, neg_b_d;
  logic [DivResultWidth-1:0] result_q, result_d;
  logic [64:0]               step_out;
  logic                      op_neg_a;
  logic                      op_neg_b;

  div_step u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_out)
  );

  assign op_neg_a = signed_div_i & opdata1_i[31];
  assign op_neg_b = signed_div_i & opdata2_i[31];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    result_d  = result_q;
    case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          neg_a_d   = op_neg_a;
          neg_b_d   = op_neg_b;
          divisor_d = op_neg_b ? (~opdata2_i + 32'd1) : opdata2_i;
          work_d    = {33'd0, op_neg_a ? (~opdata1_i + 32'd1) : opdata1_i};
          cnt_d     = 5'd0;
          state_d   = (opdata2_i == 32'd0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
          work_d  = 65'd0;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
          work_d  = 65'd0;
          cnt_d   = 5'd0;
        end else begin
          work_d = step_out;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == DivLastStep) begin
            state_d  = DivEnd;
            cnt_d    = 5'd0;
            result_d = div_sign_fix(step_out[31:0], step_out[63:32], neg_a_q, neg_b_q);
          end
        end
      end
      default: begin
        // annul_i is deliberately not looked at here: the result is already committed.
        if (start_i == DivStop) begin
          state_d  = DivFree;
          work_d   = 65'd0;
          result_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= 5'd0;
      work_q    <= 65'd0;
      divisor_q <= 32'd0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == DivEnd) ? DivResultReady : DivResultNotReady;
  assign result_o = (state_q == DivEnd) ? result_q : 64'd0;

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against a plain-arithmetic
// reference (64-bit integer divide), plus directed corner scenarios.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Truncating division in 64-bit arithmetic; remainder keeps the dividend's sign.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int lat;
    exp = ref_div(s, a, b);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_div_i = ~s;
    while (!ready_o && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_val("latency", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
    check_val("result", result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val("hold_ready", 64'(ready_o), 64'd1);
      check_val("hold_result", result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    check_val("drop_ready", 64'(ready_o), 64'd0);
    check_val("drop_result", result_o, 64'd0);
    $display("div s=%0d a=%h b=%h -> rem=%h quo=%h lat=%0d", s, a, b, exp[63:32], exp[31:0], lat);
  endtask

  task automatic watch_no_ready(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check_val(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check_val("reset_ready", 64'(ready_o), 64'd0);
    check_val("reset_result", result_o, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, 0);
    run_div(1'b0, 32'h12345678, 32'd0, 0);

    // Annul mid-divide: no ready pulse, then a fresh divide runs normally.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check_val("annul_ready", 64'(ready_o), 64'd0);
    watch_no_ready("annul_no_ready", 40);
    $display("annul at step 10 done");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, 0);

    // Reset mid-divide.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd5000;
    opdata2_i    = 32'd9;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("rst_mid_ready", 64'(ready_o), 64'd0);
    check_val("rst_mid_result", result_o, 64'd0);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    watch_no_ready("rst_no_ready", 40);
    $display("reset during step 20 done");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);

    // Held start in END, then back-to-back divides.
    run_div(1'b0, 32'd123456, 32'd789, 5);
    run_div(1'b1, 32'h80000000, 32'd1, 2);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = {{16{1'b1}}, 16'($urandom)};
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      run_div(s, a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
